lc3_int_ctrl: RTL and testbench

Parametrised interrupt controller for the LC3 system: replaces the single fixed interrupt source feeding the FSM `INT` input and the `INT_Priority` bus with `NCH` independently configurable request channels. Each channel has a programmable priority, enable and edge/level mode. The block arbitrates among requests and presents one interrupt, with its priority and vector, to the FSM and CPU only when the request outranks the current PSR priority. It sits beside G_MEMORY. Its configuration port is driven from the memory-mapped device-register decode, and `int_ack` is driven from the FSM's `LD_Vector`.

---
 rtl/lc3_int_ctrl.sv | 148 ++++++++++++++
 tb/tb_lc3_int_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_int_ctrl.sv
// lc3_int_ctrl: NCH-channel prioritised interrupt controller for the LC3.
// Presents the highest-priority enabled request that outranks the PSR priority.
module lc3_int_ctrl #(
    parameter int unsigned     NCH   = 8,
    parameter int unsigned     PW    = 3,
    parameter int unsigned     VW    = 8,
    parameter logic [VW-1:0]   VBASE = 8'h80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  irq,
    input  logic [PW-1:0]   cpu_pri,
    input  logic            int_ack,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_sel,
    input  logic [3:0]      cfg_ch,
    input  logic [15:0]     cfg_wdata,
    output logic [15:0]     cfg_rdata,
    output logic            INT,
    output logic [PW-1:0]   INT_Priority,
    output logic [VW-1:0]   int_vector,
    output logic [NCH-1:0]  pending
);
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t state, state_next;

    logic [NCH-1:0] irq_m, irq_s, irq_d;
    logic [NCH-1:0] enable, edge_en, pend_next, ack_clr, w1c_clr;
    logic [PW-1:0]  prio [NCH];
    logic [IW-1:0]  win, pres_ch;
    logic [PW-1:0]  win_prio;
    logic           win_valid, req, ack_take;
    logic           unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_m <= '0;
            irq_s <= '0;
            irq_d <= '0;
        end else begin
            irq_m <= irq;
            irq_s <= irq_m;
            irq_d <= irq_s;
        end
    end

    // Strict '>' keeps the lowest index on ties; prio 0 never beats the initial 0.
    always_comb begin
        win       = '0;
        win_prio  = '0;
        win_valid = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
                win       = IW'(i);
                win_prio  = prio[i];
                win_valid = 1'b1;
            end
        end
    end

    assign req      = win_valid && (win_prio > cpu_pri);
    assign ack_take = int_ack && (state == REQ);
    assign w1c_clr  = (cfg_we && cfg_sel == 2'b11) ? cfg_wdata[NCH-1:0] : '0;

    // The ack clears the channel that was presented, not the live winner.
    always_comb begin
        ack_clr   = '0;
        pend_next = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ack_clr[i] = ack_take && (pres_ch == IW'(i));
            if (edge_en[i])
                pend_next[i] = (irq_s[i] & ~irq_d[i]) | (pending[i] & ~(ack_clr[i] | w1c_clr[i]));
            else
                pend_next[i] = irq_s[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) prio[i] <= '0;
            enable  <= '0;
            edge_en <= '0;
            pending <= '0;
        end else begin
            pending <= pend_next;
            if (cfg_we) begin
                case (cfg_sel)
                    2'b00: begin
                        for (int unsigned i = 0; i < NCH; i++)
                            if (cfg_ch == 4'(i)) prio[i] <= cfg_wdata[PW-1:0];
                    end
                    2'b01:   enable  <= cfg_wdata[NCH-1:0];
                    2'b10:   edge_en <= cfg_wdata[NCH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_sel)
            2'b00: begin
                for (int unsigned i = 0; i < NCH; i++)
                    if (cfg_ch == 4'(i)) cfg_rdata[PW-1:0] = prio[i];
            end
            2'b01:   cfg_rdata[NCH-1:0] = enable;
            2'b10:   cfg_rdata[NCH-1:0] = edge_en;
            default: cfg_rdata[NCH-1:0] = pending;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        INT        = 1'b0;
        case (state)
            IDLE: if (req) state_next = REQ;
            REQ: begin
                INT = 1'b1;
                if (int_ack)   state_next = HOLD;
                else if (!req) state_next = IDLE;
            end
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            INT_Priority <= '0;
            int_vector   <= VBASE;
            pres_ch      <= '0;
        end else if (state != HOLD) begin
            INT_Priority <= win_prio;
            int_vector   <= VBASE + VW'(win);
            pres_ch      <= win;
        end
    end
endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Self-checking bench for lc3_int_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_lc3_int_ctrl;
    localparam int NCH = 8;
    localparam int PW  = 3;
    localparam int VW  = 8;
    localparam logic [7:0] VBASE = 8'h80;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  irq;
    logic [PW-1:0]   cpu_pri;
    logic            int_ack;
    logic            cfg_we;
    logic [1:0]      cfg_sel;
    logic [3:0]      cfg_ch;
    logic [15:0]     cfg_wdata;
    logic [15:0]     cfg_rdata;
    logic            INT;
    logic [PW-1:0]   INT_Priority;
    logic [VW-1:0]   int_vector;
    logic [NCH-1:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_int_ctrl #(.NCH(NCH), .PW(PW), .VW(VW), .VBASE(VBASE)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .cpu_pri(cpu_pri), .int_ack(int_ack),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .INT(INT), .INT_Priority(INT_Priority),
        .int_vector(int_vector), .pending(pending)
    );

    always #5 clk = ~clk;

    // Behavioural model: irq sample history, channel config, pending set,
    // and a three-phase view of the request (0 quiet, 1 asserted, 2 holdoff).
    logic [NCH-1:0] m_q1, m_s, m_d, m_pend, m_en, m_edge;
    int             m_prio [NCH];
    int             m_phase, m_pres;
    logic [PW-1:0]  m_pri_out;
    logic [7:0]     m_vec_out;

    task automatic model_reset();
        m_q1 = '0; m_s = '0; m_d = '0; m_pend = '0; m_en = '0; m_edge = '0;
        for (int i = 0; i < NCH; i++) m_prio[i] = 0;
        m_phase = 0; m_pres = 0; m_pri_out = '0; m_vec_out = VBASE;
    endtask

    // Highest priority first, then lowest index.
    function automatic int winner();
        for (int p = (1 << PW) - 1; p >= 1; p--)
            for (int i = 0; i < NCH; i++)
                if (m_pend[i] && m_en[i] && m_prio[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_rdata();
        logic [15:0] r;
        r = '0;
        case (cfg_sel)
            2'b00: if (int'(cfg_ch) < NCH) r = 16'(m_prio[cfg_ch]);
            2'b01: r[NCH-1:0] = m_en;
            2'b10: r[NCH-1:0] = m_edge;
            default: r[NCH-1:0] = m_pend;
        endcase
        return r;
    endfunction

    task automatic model_step();
        int w;
        bit rq, rise, clr;
        logic [NCH-1:0] np;
        w  = winner();
        rq = (w >= 0) && (m_prio[w] > int'(cpu_pri));
        np = '0;
        for (int i = 0; i < NCH; i++) begin
            if (m_edge[i]) begin
                rise  = m_s[i] && !m_d[i];
                clr   = (int_ack && m_phase == 1 && m_pres == i) ||
                        (cfg_we && cfg_sel == 2'b11 && cfg_wdata[i]);
                np[i] = rise || (m_pend[i] && !clr);
            end else begin
                np[i] = m_s[i];
            end
        end
        if (m_phase != 2) begin
            m_pres    = (w >= 0) ? w : 0;
            m_pri_out = (w >= 0) ? PW'(m_prio[w]) : '0;
            m_vec_out = VBASE + 8'(m_pres);
        end
        case (m_phase)
            0:       m_phase = rq ? 1 : 0;
            1:       m_phase = int_ack ? 2 : (rq ? 1 : 0);
            default: m_phase = 0;
        endcase
        if (cfg_we) begin
            case (cfg_sel)
                2'b00: if (int'(cfg_ch) < NCH) m_prio[cfg_ch] = int'(cfg_wdata[PW-1:0]);
                2'b01: m_en   = cfg_wdata[NCH-1:0];
                2'b10: m_edge = cfg_wdata[NCH-1:0];
                default: ;
            endcase
        end
        m_d = m_s; m_s = m_q1; m_q1 = irq; m_pend = np;
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; irq = '0; cpu_pri = '0; int_ack = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'b00; cfg_ch = '0; cfg_wdata = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] ch, input logic [15:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_wdata = data;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({INT, INT_Priority, int_vector, pending} !== {1'b0, 3'd0, 8'h80, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: got INT=%b pri=%0d vec=%h pend=%h, want 0 0 80 00",
                     INT, INT_Priority, int_vector, pending);
        end
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s); cfg_ch = 4'(s + 3);
            #1;
            n_checks++;
            if (cfg_rdata !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_rdata sel=%0d: got %h want 0000", s, cfg_rdata);
            end
        end
        cfg_sel = 2'b00; cfg_ch = '0;
    endtask

    task automatic test_single_edge();
        do_reset();
        cfg_write(2'b00, 4'd3, 16'd4);
        cfg_write(2'b01, 4'd0, 16'h0008);
        cfg_write(2'b10, 4'd0, 16'h0008);
        cfg_sel = 2'b00; cfg_ch = 4'd3; #1;
        n_checks++;
        if (cfg_rdata !== 16'h0004) begin
            n_fail++; $display("FAIL single_prio_read: got %h want 0004", cfg_rdata);
        end
        irq = 8'h08;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (INT !== (k == 4)) begin
                n_fail++; $display("FAIL single_latency edge %0d: got INT=%b want %b", k, INT, k == 4);
            end
        end
        irq = '0;
        n_checks++;
        if ({INT_Priority, int_vector, pending[3]} !== {3'd4, 8'h83, 1'b1}) begin
            n_fail++;
            $display("FAIL single_present: got pri=%0d vec=%h pend3=%b want 4 83 1",
                     INT_Priority, int_vector, pending[3]);
        end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_checks++;
        if ({INT, pending[3]} !== 2'b00) begin
            n_fail++; $display("FAIL single_ack: got INT=%b pend3=%b want 0 0", INT, pending[3]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (INT !== 1'b0) begin
                n_fail++; $display("FAIL single_after_ack cycle %0d: got INT=%b want 0", k, INT);
            end
        end
    endtask

    task automatic test_tie_mask();
        do_reset();
        cfg_write(2'b00, 4'd1, 16'd6);
        cfg_write(2'b00, 4'd5, 16'd6);
        cfg_write(2'b00, 4'd2, 16'd7);
        cfg_write(2'b01, 4'd0, 16'h0022);
        cfg_write(2'b10, 4'd0, 16'h0026);
        irq = 8'h26; tick(5); irq = '0;
        n_checks++;
        if ({INT, INT_Priority, int_vector} !== {1'b1, 3'd6, 8'h81}) begin
            n_fail++;
            $display("FAIL tie_lowest: got INT=%b pri=%0d vec=%h want 1 6 81", INT, INT_Priority, int_vector);
        end
        cfg_write(2'b01, 4'd0, 16'h0026);
        n_checks++;
        if (int_vector !== 8'h81) begin
            n_fail++; $display("FAIL unmask_delay: got vec=%h want 81", int_vector);
        end
        tick();
        n_checks++;
        if ({INT, INT_Priority, int_vector} !== {1'b1, 3'd7, 8'h82}) begin
            n_fail++;
            $display("FAIL unmask_win: got INT=%b pri=%0d vec=%h want 1 7 82", INT, INT_Priority, int_vector);
        end
    endtask

    task automatic test_cpu_pri();
        do_reset();
        cfg_write(2'b00, 4'd0, 16'd3);
        cfg_write(2'b01, 4'd0, 16'h0001);
        cfg_write(2'b10, 4'd0, 16'h0001);
        cpu_pri = 3'd3; irq = 8'h01; tick(5); irq = '0;
        n_checks++;
        if ({INT, pending[0]} !== 2'b01) begin
            n_fail++; $display("FAIL pri_equal: got INT=%b pend0=%b want 0 1", INT, pending[0]);
        end
        cpu_pri = 3'd2; tick();
        n_checks++;
        if ({INT, INT_Priority, int_vector} !== {1'b1, 3'd3, 8'h80}) begin
            n_fail++;
            $display("FAIL pri_lower: got INT=%b pri=%0d vec=%h want 1 3 80", INT, INT_Priority, int_vector);
        end
        cpu_pri = 3'd5; tick();
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++; $display("FAIL pri_raise: got INT=%b want 0", INT);
        end
        cpu_pri = '0;
    endtask

    task automatic test_level();
        do_reset();
        cfg_write(2'b00, 4'd4, 16'd5);
        cfg_write(2'b01, 4'd0, 16'h0010);
        irq = 8'h10; tick(4);
        n_checks++;
        if ({INT, INT_Priority, int_vector} !== {1'b1, 3'd5, 8'h84}) begin
            n_fail++;
            $display("FAIL level_req: got INT=%b pri=%0d vec=%h want 1 5 84", INT, INT_Priority, int_vector);
        end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({INT, pending[4]} !== 2'b01) begin
                n_fail++; $display("FAIL level_hold cycle %0d: got INT=%b pend4=%b want 0 1", k, INT, pending[4]);
            end
            tick();
        end
        n_checks++;
        if (INT !== 1'b1) begin
            n_fail++; $display("FAIL level_rereq: got INT=%b want 1", INT);
        end
        irq = '0; tick(2);
        n_checks++;
        if (pending[4] !== 1'b1) begin
            n_fail++; $display("FAIL level_sync_delay: got pend4=%b want 1", pending[4]);
        end
        tick();
        n_checks++;
        if (pending[4] !== 1'b0) begin
            n_fail++; $display("FAIL level_drop: got pend4=%b want 0", pending[4]);
        end
    endtask

    task automatic test_edge_collision();
        do_reset();
        cfg_write(2'b00, 4'd6, 16'd2);
        cfg_write(2'b01, 4'd0, 16'h0040);
        cfg_write(2'b10, 4'd0, 16'h0040);
        irq = 8'h40; tick(4);
        irq = '0; tick(3);
        n_checks++;
        if ({INT, int_vector} !== {1'b1, 8'h86}) begin
            n_fail++; $display("FAIL coll_req: got INT=%b vec=%h want 1 86", INT, int_vector);
        end
        irq = 8'h40; tick(2);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_checks++;
        if ({INT, pending[6]} !== 2'b01) begin
            n_fail++; $display("FAIL coll_set_wins: got INT=%b pend6=%b want 0 1", INT, pending[6]);
        end
        cfg_write(2'b11, 4'd0, 16'h0040);
        n_checks++;
        if (pending[6] !== 1'b0) begin
            n_fail++; $display("FAIL coll_w1c: got pend6=%b want 0", pending[6]);
        end
        tick(2);
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++; $display("FAIL coll_idle: got INT=%b want 0", INT);
        end
        irq = '0;
    endtask

    task automatic test_reset_midreq();
        do_reset();
        cfg_write(2'b00, 4'd7, 16'd7);
        cfg_write(2'b01, 4'd0, 16'h0080);
        irq = 8'h80; tick(4);
        n_checks++;
        if (INT !== 1'b1) begin
            n_fail++; $display("FAIL midreq_setup: got INT=%b want 1", INT);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({INT, INT_Priority, int_vector} !== {1'b0, 3'd0, 8'h80}) begin
            n_fail++;
            $display("FAIL midreq_async: got INT=%b pri=%0d vec=%h want 0 0 80", INT, INT_Priority, int_vector);
        end
        model_reset();
        irq = '0;
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s); cfg_ch = 4'd7; #1;
            n_checks++;
            if (cfg_rdata !== 16'h0000) begin
                n_fail++; $display("FAIL midreq_rdata sel=%0d: got %h want 0000", s, cfg_rdata);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        n_checks++;
        if ({INT, INT_Priority, int_vector, pending} !== {1'b0, 3'd0, 8'h80, 8'h00}) begin
            n_fail++;
            $display("FAIL idle_ack: got INT=%b pri=%0d vec=%h pend=%h want 0 0 80 00",
                     INT, INT_Priority, int_vector, pending);
        end
        tick();
        n_checks++;
        if (INT !== 1'b0) begin
            n_fail++; $display("FAIL idle_ack_after: got INT=%b want 0", INT);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(9) == 0) irq[i] = ~irq[i];
            if ($urandom_range(15) == 0) cpu_pri = PW'($urandom_range(7));
            int_ack   = ($urandom_range(3) == 0);
            cfg_we    = ($urandom_range(5) == 0);
            cfg_sel   = 2'($urandom_range(3));
            cfg_ch    = 4'($urandom_range(15));
            cfg_wdata = 16'($urandom);
            if (cfg_we && cfg_sel == 2'b11 && $urandom_range(2) != 0) cfg_we = 1'b0;
            tick();
            n_checks++;
            if ({INT, INT_Priority, int_vector, pending} !==
                {(m_phase == 1), m_pri_out, m_vec_out, m_pend}) begin
                n_fail++;
                $display("FAIL random_out cycle %0d: got INT=%b pri=%0d vec=%h pend=%h want %b %0d %h %h",
                         c, INT, INT_Priority, int_vector, pending,
                         m_phase == 1, m_pri_out, m_vec_out, m_pend);
            end
            n_checks++;
            if (cfg_rdata !== m_rdata()) begin
                n_fail++;
                $display("FAIL random_rdata cycle %0d sel=%0d ch=%0d: got %h want %h",
                         c, cfg_sel, cfg_ch, cfg_rdata, m_rdata());
            end
        end
        cfg_we = 1'b0; int_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; cpu_pri = '0; int_ack = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_ch = '0; cfg_wdata = '0;
        model_reset();
        test_reset();
        test_single_edge();
        test_tie_mask();
        test_cpu_pri();
        test_level();
        test_edge_collision();
        test_reset_midreq();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
